// File: rtl/alu_register_pkg.sv
// Shared definitions for the alu_register block: datapath width, register
// count and index width, and the ALU operation codes.
package alu_register_pkg;

  localparam int DATA_W    = 16;
  localparam int NUM_REGS  = 4;
  localparam int REG_IDX_W = $clog2(NUM_REGS);
  localparam int ALU_OP_W  = 4;

  // ALU operation select codes; every other code produces zero.
  localparam logic [ALU_OP_W-1:0] ALU_ADD   = 4'd0;
  localparam logic [ALU_OP_W-1:0] ALU_SUB   = 4'd1;
  localparam logic [ALU_OP_W-1:0] ALU_AND   = 4'd2;
  localparam logic [ALU_OP_W-1:0] ALU_OR    = 4'd3;
  localparam logic [ALU_OP_W-1:0] ALU_NOT   = 4'd4;
  localparam logic [ALU_OP_W-1:0] ALU_TCP   = 4'd5;
  localparam logic [ALU_OP_W-1:0] ALU_SHL   = 4'd6;
  localparam logic [ALU_OP_W-1:0] ALU_SHR   = 4'd7;
  localparam logic [ALU_OP_W-1:0] ALU_PASSA = 4'd8;
  localparam logic [ALU_OP_W-1:0] ALU_PASSB = 4'd9;

  // A register write is architectural only when both the request and the
  // commit strobe are present in the same cycle.
  function automatic logic writeQualified(input logic regWrite,
                                          input logic pvsWriteEn);
    return regWrite & pvsWriteEn;
  endfunction

endpackage

// File: rtl/alu_register_if.sv
// Bundle of the register-file and ALU signals for alu_register.
// The master side (the environment) drives the requests and operands;
// the slave side (the block) returns read data and the ALU result.
interface alu_register_if;
  import alu_register_pkg::*;

  logic                 PVSWriteEn;
  logic                 RegWrite;
  logic [REG_IDX_W-1:0] readReg1;
  logic [REG_IDX_W-1:0] readReg2;
  logic [REG_IDX_W-1:0] writeReg;
  logic [DATA_W-1:0]    writeData;
  logic [DATA_W-1:0]    readData1;
  logic [DATA_W-1:0]    readData2;
  logic [DATA_W-1:0]    A;
  logic [DATA_W-1:0]    B;
  logic [ALU_OP_W-1:0]  ALUOp;
  logic [DATA_W-1:0]    C;

  modport master (
    output PVSWriteEn, RegWrite, readReg1, readReg2, writeReg, writeData,
    output A, B, ALUOp,
    input  readData1, readData2, C
  );

  modport slave (
    input  PVSWriteEn, RegWrite, readReg1, readReg2, writeReg, writeData,
    input  A, B, ALUOp,
    output readData1, readData2, C
  );

endinterface

// File: rtl/alu_register_alu_unit.sv
// Purely combinational ALU used by alu_register. Arithmetic wraps at the
// word width with no carry/overflow; shifts use only the low four bits of B.
module alu_unit
  import alu_register_pkg::*;
#(
  parameter int DATA_W_P = DATA_W
) (
  input  logic [DATA_W_P-1:0] a_i,
  input  logic [DATA_W_P-1:0] b_i,
  input  logic [ALU_OP_W-1:0] op_i,
  output logic [DATA_W_P-1:0] c_o
);

  logic [3:0] shAmt;

  assign shAmt = b_i[3:0];

  // Select the result for the current operation; unused codes give zero.
  always_comb begin
    c_o = '0;
    case (op_i)
      ALU_ADD:   c_o = a_i + b_i;
      ALU_SUB:   c_o = a_i - b_i;
      ALU_AND:   c_o = a_i & b_i;
      ALU_OR:    c_o = a_i | b_i;
      ALU_NOT:   c_o = ~a_i;
      ALU_TCP:   c_o = '0 - a_i;
      ALU_SHL:   c_o = a_i << shAmt;
      ALU_SHR:   c_o = DATA_W_P'($signed(a_i) >>> shAmt);
      ALU_PASSA: c_o = a_i;
      ALU_PASSB: c_o = b_i;
      default:   c_o = '0;
    endcase
  end

endmodule

// File: rtl/alu_register.sv
// Register file with two combinational read ports and one gated write port,
// alongside a combinational ALU (alu_unit).
// Optional build macro REGFILE_BYPASS_EN: when defined, a read of the index
// being written in a committing cycle returns writeData immediately.
module alu_register #(
  parameter int DATA_W_P   = alu_register_pkg::DATA_W,
  parameter int NUM_REGS_P = alu_register_pkg::NUM_REGS
) (
  input  logic          clk,
  input  logic          reset_n,
  alu_register_if.slave bus
);
  import alu_register_pkg::*;

  logic [DATA_W_P-1:0] regs_q [NUM_REGS_P];
  logic [DATA_W_P-1:0] regs_d [NUM_REGS_P];
  logic                wrEn;
  logic [DATA_W_P-1:0] rdData1;
  logic [DATA_W_P-1:0] rdData2;

  assign wrEn = writeQualified(bus.RegWrite, bus.PVSWriteEn);

  // Next register-file contents: only the addressed entry changes, and only
  // on a committed write; r0 is an ordinary register.
  always_comb begin
    regs_d = regs_q;
    if (wrEn) begin
      regs_d[bus.writeReg] = bus.writeData;
    end
  end

  // Register-file storage; reset clears every entry without waiting for clk.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NUM_REGS_P; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      regs_q <= regs_d;
    end
  end

  // Combinational read ports, with optional write-to-read forwarding that is
  // suppressed during reset so reads still show cleared registers.
  always_comb begin
    rdData1 = regs_q[bus.readReg1];
    rdData2 = regs_q[bus.readReg2];
`ifdef REGFILE_BYPASS_EN
    if (wrEn && reset_n && (bus.readReg1 == bus.writeReg)) begin
      rdData1 = bus.writeData;
    end
    if (wrEn && reset_n && (bus.readReg2 == bus.writeReg)) begin
      rdData2 = bus.writeData;
    end
`endif
  end

  assign bus.readData1 = rdData1;
  assign bus.readData2 = rdData2;

  alu_unit #(
    .DATA_W_P (DATA_W_P)
  ) u_alu (
    .a_i  (bus.A),
    .b_i  (bus.B),
    .op_i (bus.ALUOp),
    .c_o  (bus.C)
  );

endmodule

// File: tb/tb_alu_register.sv
// Scoreboard bench for alu_register. Stimulus pushes expected read data and
// ALU results into a queue; a monitor pops and compares on each falling edge.
module tb_alu_register;
  import alu_register_pkg::*;

  logic clk = 1'b0;
  logic reset_n;

  always #5 clk = ~clk;

  alu_register_if bus();

  alu_register dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus)
  );

  typedef struct packed {
    logic [1:0]  sel;
    logic [15:0] tag;
    logic [15:0] expVal;
  } expT;

  expT         sb[$];
  int          checks = 0;
  int          errors = 0;
  int          stepNo = 0;
  logic [15:0] model [4];

  // Reference ALU written from the operation rules using integer arithmetic.
  function automatic logic [15:0] refAlu(input logic [3:0] op,
                                         input logic [15:0] a,
                                         input logic [15:0] b);
    longint ai, bi, sa, r, p;
    int sh;
    ai = longint'(a);
    bi = longint'(b);
    sh = int'(b % 16);
    p  = longint'(1) << sh;
    r  = 0;
    case (op)
      4'd0: r = (ai + bi) % 65536;
      4'd1: r = (ai - bi + 65536) % 65536;
      4'd2: r = longint'(a & b);
      4'd3: r = longint'(a | b);
      4'd4: r = 65535 - ai;
      4'd5: r = (65536 - ai) % 65536;
      4'd6: r = (ai * p) % 65536;
      4'd7: begin
        sa = (ai >= 32768) ? ai - 65536 : ai;
        if (sa >= 0) r = sa / p;
        else         r = -((-sa + p - 1) / p);
        r = (r + 65536) % 65536;
      end
      4'd8: r = ai;
      4'd9: r = bi;
      default: r = 0;
    endcase
    return 16'(r);
  endfunction

  // Expected value seen on a read port for the inputs currently driven.
  function automatic logic [15:0] refRead(input logic [1:0] idx);
    if (!reset_n) return 16'h0000;
`ifdef REGFILE_BYPASS_EN
    if (bus.RegWrite && bus.PVSWriteEn && (idx == bus.writeReg))
      return bus.writeData;
`endif
    return model[idx];
  endfunction

  task automatic pushExpected();
    stepNo++;
    sb.push_back({2'd0, 16'(stepNo), refRead(bus.readReg1)});
    sb.push_back({2'd1, 16'(stepNo), refRead(bus.readReg2)});
    sb.push_back({2'd2, 16'(stepNo), refAlu(bus.ALUOp, bus.A, bus.B)});
  endtask

  // Drive one cycle of inputs, record expectations, then advance the model
  // across the rising edge.
  task automatic applyStimulus(input logic we, input logic pvs,
                               input logic [1:0] wr, input logic [15:0] wd,
                               input logic [1:0] r1, input logic [1:0] r2,
                               input logic [15:0] a, input logic [15:0] b,
                               input logic [3:0] op);
    bus.RegWrite   = we;
    bus.PVSWriteEn = pvs;
    bus.writeReg   = wr;
    bus.writeData  = wd;
    bus.readReg1   = r1;
    bus.readReg2   = r2;
    bus.A          = a;
    bus.B          = b;
    bus.ALUOp      = op;
    pushExpected();
    @(posedge clk);
    if (reset_n && we && pvs) model[wr] = wd;
    #1;
  endtask

  task automatic checkOutput(input expT e);
    logic [15:0] act;
    string nm;
    case (e.sel)
      2'd0:    begin act = bus.readData1; nm = "readData1"; end
      2'd1:    begin act = bus.readData2; nm = "readData2"; end
      default: begin act = bus.C;         nm = "C";         end
    endcase
    checks++;
    if (act !== e.expVal) begin
      errors++;
      $display("[TB] FAIL step %0d %s got 0x%04h expected 0x%04h",
               e.tag, nm, act, e.expVal);
    end
  endtask

  // Monitor: compare everything queued for this cycle at the falling edge.
  initial begin
    expT e;
    forever begin
      @(negedge clk);
      while (sb.size() > 0) begin
        e = sb.pop_front();
        checkOutput(e);
      end
    end
  end

  // Watchdog so the run always ends.
  initial begin
    #200000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] timeout");
  end

  initial begin
    reset_n = 1'b0;
    bus.RegWrite = 1'b0; bus.PVSWriteEn = 1'b0;
    bus.writeReg = '0; bus.writeData = '0;
    bus.readReg1 = '0; bus.readReg2 = '0;
    bus.A = '0; bus.B = '0; bus.ALUOp = '0;
    for (int i = 0; i < 4; i++) model[i] = 16'h0000;
    @(posedge clk); #1;

    // Reset values, including a write attempt that reset must block.
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h0003, 16'h0004, ALU_ADD);
    applyStimulus(1'b1, 1'b1, 2'd1, 16'h5555, 2'd1, 2'd2, 16'h0000, 16'h0000, ALU_PASSA);
    reset_n = 1'b1;
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd1, 2'd0, 16'h0000, 16'h0000, ALU_ADD);

    // Write gating on the commit strobe.
    applyStimulus(1'b1, 1'b0, 2'd2, 16'hBEEF, 2'd2, 2'd2, 16'h0000, 16'h0000, ALU_ADD);
    applyStimulus(1'b0, 1'b0, 2'd2, 16'hBEEF, 2'd2, 2'd2, 16'h0000, 16'h0000, ALU_ADD);
    applyStimulus(1'b1, 1'b1, 2'd2, 16'hBEEF, 2'd2, 2'd1, 16'h0000, 16'h0000, ALU_ADD);
    applyStimulus(1'b0, 1'b1, 2'd2, 16'h0000, 2'd2, 2'd2, 16'h0000, 16'h0000, ALU_ADD);

    // Dual read of r0 and r3.
    applyStimulus(1'b1, 1'b1, 2'd0, 16'h0005, 2'd0, 2'd3, 16'h0000, 16'h0000, ALU_ADD);
    applyStimulus(1'b1, 1'b1, 2'd3, 16'hFFFB, 2'd0, 2'd3, 16'h0000, 16'h0000, ALU_ADD);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h0000, 16'h0000, ALU_ADD);

    // ALU arithmetic and shift corners.
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h7FFF, 16'h0001, ALU_ADD);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h7FFF, 16'h0001, ALU_SUB);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h0005, 16'h0001, ALU_TCP);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h00FF, 16'h0001, ALU_NOT);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h0012, 16'h0008, ALU_SHL);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h8004, 16'h0001, ALU_SHR);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h8004, 16'h00F3, ALU_SHR);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd0, 2'd3, 16'h1234, 16'h5678, 4'd12);

    // Same-cycle read and write of r1.
    applyStimulus(1'b1, 1'b1, 2'd1, 16'h0001, 2'd0, 2'd2, 16'h0000, 16'h0000, ALU_ADD);
    applyStimulus(1'b1, 1'b1, 2'd1, 16'h00AA, 2'd1, 2'd1, 16'h0000, 16'h0000, ALU_ADD);
    applyStimulus(1'b0, 1'b0, 2'd1, 16'h0000, 2'd1, 2'd1, 16'h0000, 16'h0000, ALU_ADD);

    // Asynchronous reset mid-cycle after r1 holds 0x1234.
    applyStimulus(1'b1, 1'b1, 2'd1, 16'h1234, 2'd1, 2'd0, 16'h0000, 16'h0000, ALU_ADD);
    bus.RegWrite = 1'b0; bus.PVSWriteEn = 1'b0;
    bus.readReg1 = 2'd1; bus.readReg2 = 2'd2;
    #1;
    reset_n = 1'b0;
    for (int i = 0; i < 4; i++) model[i] = 16'h0000;
    pushExpected();
    @(posedge clk); #1;
    applyStimulus(1'b1, 1'b1, 2'd3, 16'h7777, 2'd1, 2'd3, 16'h0000, 16'h0000, ALU_ADD);
    reset_n = 1'b1;
    applyStimulus(1'b1, 1'b1, 2'd3, 16'h7777, 2'd1, 2'd2, 16'h0000, 16'h0000, ALU_ADD);
    applyStimulus(1'b0, 1'b0, 2'd0, 16'h0000, 2'd3, 2'd1, 16'h0000, 16'h0000, ALU_ADD);

    // Randomized traffic against the reference model.
    for (int n = 0; n < 300; n++) begin
      applyStimulus(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                    2'($urandom_range(0, 3)), 16'($urandom),
                    2'($urandom_range(0, 3)), 2'($urandom_range(0, 3)),
                    16'($urandom), 16'($urandom), 4'($urandom_range(0, 15)));
    end

    @(negedge clk); #1;
    checks++;
    if (sb.size() != 0) begin
      errors++;
      $display("[TB] FAIL scoreboard_drain got %0d entries expected 0", sb.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_register.md
ALU_REGISTER -- requirements
Module: alu_register

Interface
REQ-001 Parameter: DATA_W, 16, datapath word width in bits.
REQ-002 Parameter: NUM_REGS, 4, number of general registers; index width is log2(NUM_REGS) = 2.
REQ-003 Clock and reset: one clock; reset is asynchronous and active-low.
REQ-004 clk  input  1  rising-edge clock.
REQ-005 reset_n  input  1  asynchronous active-low reset.
REQ-006 PVSWriteEn  input  1  architectural-state commit strobe; a register write takes effect only when it is high.
REQ-007 RegWrite  input  1  register write request.
REQ-008 readReg1, readReg2  input  2 each  read-port register indices.
REQ-009 writeReg  input  2  write-port register index.
REQ-010 writeData  input  DATA_W  write-port data.
REQ-011 readData1, readData2  output  DATA_W each  read-port data.
REQ-012 A, B  input  DATA_W each  ALU operands.
REQ-013 ALUOp  input  4  ALU operation select.
REQ-014 C  output  DATA_W  ALU result.

Function
REQ-015 Register file: NUM_REGS x DATA_W storage; all entries are writable, and r0 is not hardwired.
REQ-016 Reads are combinational: readDataN equals reg[readRegN] in the same cycle, with no clock latency.
REQ-017 Write: at the rising clk edge, reg[writeReg] <= writeData only when RegWrite=1 and PVSWriteEn=1; otherwise every register holds its value.
REQ-018 Reading the register being written in the same cycle returns the old value until the edge, unless REGFILE_BYPASS_EN is defined (see REQ-026).
REQ-019 ALU is purely combinational; C settles in the same cycle as A, B and ALUOp.
REQ-020 ALUOp encoding: 0 ADD A+B; 1 SUB A-B; 2 AND; 3 OR; 4 NOT A; 5 TCP (0-A); 6 SHL A<<B[3:0]; 7 SHR arithmetic A>>>B[3:0] (sign-fill); 8 PASS A; 9 PASS B; 10-15 C=0.
REQ-021 Arithmetic wraps modulo 2^DATA_W; no carry or overflow output is produced; 0x7FFF+1 = 0x8000.
REQ-022 Shift amounts use only B[3:0]; SHL with B=8 implements LHI (imm<<8), and B=1 implements single-bit shifts.

Reset
REQ-023 While reset_n=0, all registers are cleared to 0 immediately, asynchronously to clk.
REQ-024 Reset overrides any write in the same cycle; after reset is released, the first write occurs at the first qualified rising edge.
REQ-025 Output reset values: readData1/readData2 read 0; C follows its inputs (it is combinational).

Configuration
REQ-026 Macro REGFILE_BYPASS_EN: when defined, a read of index writeReg while RegWrite=1 and PVSWriteEn=1 returns writeData combinationally; when undefined, such a read returns the stored value (REQ-018).

Structure
REQ-027 Package alu_register_pkg holds DATA_W, the register-index width and the ALUOp constants (ALU_ADD ... ALU_PASSB).
REQ-028 The ALU is a sub-module alu_unit instantiated inside alu_register; the register file is inline.

Verification
REQ-029 Reset: drive reset_n=0 mid-cycle after writing reg1=0x1234 -> readData for reg1 reads 0 immediately.
REQ-030 Write gating: RegWrite=1, PVSWriteEn=0, writeReg=2, writeData=0xBEEF, then one edge -> reg2 stays 0; with PVSWriteEn=1 -> reg2=0xBEEF after the edge.
REQ-031 Dual read: reg0=0x0005, reg3=0xFFFB; readReg1=0, readReg2=3 -> readData1=0x0005, readData2=0xFFFB in the same cycle.
REQ-032 ALU arithmetic: A=0x7FFF, B=1: ADD -> 0x8000; SUB -> 0x7FFE; TCP with A=5 -> 0xFFFB; NOT with A=0x00FF -> 0xFF00.
REQ-033 Shifts: A=0x0012, B=8, SHL -> 0x1200; A=0x8004, B=1, SHR -> 0xC002; ALUOp=12 -> C=0.
REQ-034 Same-cycle read/write of reg1 (old value 0x0001, writeData 0x00AA) -> readData1=0x0001 without REGFILE_BYPASS_EN and 0x00AA with it; both builds read 0x00AA after the edge.
